// File: rtl/regfile_mp_pkg.sv
// regfile_pkg: shared sweep states, constants and helpers for the multi-port register file
package regfile_pkg;
    typedef enum logic {IDLE, SWEEP} clr_state_e;
    localparam int ZERO_IDX = 0;
    function automatic int clr_val(input int idx, input int sp_idx, input int sp_reset);
        return (idx == sp_idx) ? sp_reset : 0;
    endfunction
    function automatic int lsb(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/clear bus between decode, writeback and the register file
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     wr_drop;
    logic                     wr_conflict;
    logic                     wr_zero_err;
    modport master (output rd_addr, wr_en, wr_addr, wr_data, clr_req,
                    input rd_data, clr_busy, wr_drop, wr_conflict, wr_zero_err);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, clr_req,
                    output rd_data, clr_busy, wr_drop, wr_conflict, wr_zero_err);
endinterface

// File: rtl/regfile_mp_clr_seq.sv
// regfile_clr_seq: clear sweep walking entries 1..DEPTH-1 one per cycle
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = 29,
    parameter int SP_RESET = 252
) (
    input  logic              elk,
    input  logic              nrst,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] sw_addr,
    output logic [DATA_W-1:0] sw_data
);
    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge elk) begin
        if (!nrst) begin
            state_q <= IDLE;
            ptr_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // terminal check precedes increment so ptr never wraps
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q + ADDR_W'(1);
        if (state_q == IDLE) begin
            state_d = clr_req ? SWEEP : IDLE;
            ptr_d   = ADDR_W'(1);
        end else if (ptr_q == {ADDR_W{1'b1}}) begin
            state_d = IDLE;
            ptr_d   = ADDR_W'(1);
        end
    end

    assign busy    = (state_q == SWEEP);
    assign sw_addr = ptr_q;
    assign sw_data = DATA_W'(clr_val(32'(ptr_q), SP_IDX, SP_RESET));
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass, clear sweep and error flags
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int SP_IDX   = 29,
    parameter int SP_RESET = 252
) (
    input logic       elk,
    input logic       nrst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic                     wr_drop_q, wr_drop_d;
    logic                     wr_conflict_q, wr_conflict_d;
    logic                     wr_zero_err_q, wr_zero_err_d;
    logic                     busy;
    logic [ADDR_W-1:0]        sw_addr;
    logic [DATA_W-1:0]        sw_data;
    logic [ADDR_W-1:0]        wa [NUM_WR];
    logic [DATA_W-1:0]        wd [NUM_WR];
    logic [ADDR_W-1:0]        ra [NUM_RD];

    regfile_clr_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_IDX(SP_IDX), .SP_RESET(SP_RESET)) u_clr (
        .elk(elk), .nrst(nrst), .clr_req(bus.clr_req), .busy(busy), .sw_addr(sw_addr), .sw_data(sw_data)
    );

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j] = bus.wr_addr[lsb(j, ADDR_W) +: ADDR_W];
        assign wd[j] = bus.wr_data[lsb(j, DATA_W) +: DATA_W];
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign ra[i] = bus.rd_addr[lsb(i, ADDR_W) +: ADDR_W];
    end

    // mem_d is the post-edge image, so reading it gives write-first bypass with matching priority
    always_comb begin
        mem_d         = mem_q;
        rd_data_d     = '0;
        wr_drop_d     = busy && (|bus.wr_en);
        wr_conflict_d = 1'b0;
        wr_zero_err_d = wr_zero_err_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && wa[j] == ADDR_W'(ZERO_IDX)) wr_zero_err_d = 1'b1;
            for (int k = 0; k < j; k++)
                if (bus.wr_en[j] && bus.wr_en[k] && wa[j] == wa[k] && wa[j] != ADDR_W'(ZERO_IDX))
                    wr_conflict_d = 1'b1;
            if (!busy && bus.wr_en[j] && wa[j] != ADDR_W'(ZERO_IDX)) mem_d[wa[j]] = wd[j];
        end
        if (busy) mem_d[sw_addr] = sw_data;
        mem_d[ZERO_IDX] = '0;
        for (int i = 0; i < NUM_RD; i++) rd_data_d[lsb(i, DATA_W) +: DATA_W] = mem_d[ra[i]];
    end

    always_ff @(posedge elk) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(clr_val(i, SP_IDX, SP_RESET));
            rd_data_q     <= '0;
            wr_drop_q     <= 1'b0;
            wr_conflict_q <= 1'b0;
            wr_zero_err_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            rd_data_q     <= rd_data_d;
            wr_drop_q     <= wr_drop_d;
            wr_conflict_q <= wr_conflict_d;
            wr_zero_err_q <= wr_zero_err_d;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.clr_busy    = busy;
    assign bus.wr_drop     = wr_drop_q;
    assign bus.wr_conflict = wr_conflict_q;
    assign bus.wr_zero_err = wr_zero_err_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench against a behavioural register-file model
module tb_regfile_mp;
    typedef struct packed {
        logic [63:0] rd;
        logic        conf;
        logic        drop;
        logic        zerr;
        logic        busy;
    } exp_t;

    logic        elk = 1'b0;
    logic        nrst = 1'b0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q[$];
    exp_t        got;
    logic [31:0] m [32];
    int          busy_left = 0;
    logic        zerr = 1'b0;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();
    regfile_mp dut (.elk(elk), .nrst(nrst), .bus(bus));

    always #5 elk = ~elk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // model: sweep tracked as cycles remaining; entry cleared is DEPTH - remaining
    task automatic step(input logic n, input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1, input logic clr);
        exp_t e;
        int   idx;
        @(negedge elk);
        nrst = n;
        bus.wr_en = en;
        bus.wr_addr = {a1, a0};
        bus.wr_data = {d1, d0};
        bus.rd_addr = {r1, r0};
        bus.clr_req = clr;
        e = '0;
        if (!n) begin
            for (int i = 0; i < 32; i++) m[i] = (i == 29) ? 32'd252 : 32'd0;
            busy_left = 0;
            zerr = 1'b0;
        end else begin
            e.conf = en[0] && en[1] && a0 == a1 && a0 != 0;
            zerr = zerr | (en[0] && a0 == 0) | (en[1] && a1 == 0);
            e.drop = busy_left > 0 && en != 2'b00;
            if (busy_left == 0) begin
                if (en[0] && a0 != 0) m[a0] = d0;
                if (en[1] && a1 != 0) m[a1] = d1;
                if (clr) busy_left = 31;
            end else begin
                idx = 32 - busy_left;
                m[idx] = (idx == 29) ? 32'd252 : 32'd0;
                busy_left--;
            end
            e.rd = {m[r1], m[r0]};
        end
        e.zerr = zerr;
        e.busy = busy_left > 0;
        q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        step(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, r0, r1, 1'b0);
    endtask

    always @(posedge elk) begin
        #1;
        if (q.size() != 0) begin
            got = q.pop_front();
            chk("rd_data0", bus.rd_data[31:0], got.rd[31:0]);
            chk("rd_data1", bus.rd_data[63:32], got.rd[63:32]);
            chk("wr_conflict", 32'(bus.wr_conflict), 32'(got.conf));
            chk("wr_drop", 32'(bus.wr_drop), 32'(got.drop));
            chk("wr_zero_err", 32'(bus.wr_zero_err), 32'(got.zerr));
            chk("clr_busy", 32'(bus.clr_busy), 32'(got.busy));
        end
    end

    initial begin
        logic [4:0] a0;
        bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0; bus.clr_req = 1'b0;
        step(1'b0, 2'b11, 5'd3, 5'd4, 32'h1, 32'h2, 5'd3, 5'd4, 1'b1);
        step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
        idle(5'd29, 5'd5);
        step(1'b1, 2'b01, 5'd7, 5'd0, 32'hDEADBEEF, 32'd0, 5'd7, 5'd0, 1'b0);
        idle(5'd7, 5'd29);
        step(1'b1, 2'b11, 5'd3, 5'd3, 32'h11, 32'h22, 5'd3, 5'd7, 1'b0);
        idle(5'd3, 5'd3);
        step(1'b1, 2'b01, 5'd0, 5'd0, 32'h55, 32'd0, 5'd0, 5'd0, 1'b0);
        idle(5'd0, 5'd3);
        step(1'b1, 2'b11, 5'd1, 5'd29, 32'hFF, 32'hFF, 5'd0, 5'd0, 1'b0);
        step(1'b1, 2'b01, 5'd31, 5'd0, 32'hFF, 32'd0, 5'd1, 5'd29, 1'b0);
        step(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd31, 5'd1, 1'b1);
        for (int i = 0; i < 33; i++)
            step(1'b1, (i == 12) ? 2'b01 : 2'b00, 5'd10, 5'd0, 32'hABCD, 32'd0, 5'(i), 5'(i + 1), 1'b0);
        idle(5'd1, 5'd29);
        idle(5'd31, 5'd10);
        step(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++) idle(5'(i + 1), 5'd29);
        step(1'b0, 2'b01, 5'd9, 5'd0, 32'h9, 32'd0, 5'd9, 5'd29, 1'b0);
        idle(5'd1, 5'd29);
        step(1'b1, 2'b10, 5'd0, 5'd2, 32'd0, 32'h77, 5'd2, 5'd1, 1'b1);
        for (int i = 0; i < 34; i++) idle(5'(i), 5'd2);
        for (int i = 0; i < 1500; i++) begin
            a0 = 5'($urandom_range(31));
            step($urandom_range(63) != 0, 2'($urandom), a0,
                 ($urandom_range(3) == 0) ? a0 : 5'($urandom_range(31)),
                 $urandom, $urandom, 5'($urandom_range(31)), 5'($urandom_range(31)),
                 $urandom_range(39) == 0);
        end
        repeat (3) @(negedge elk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the CPU datapath. Successor to the fixed 32x32 two-read/one-write register block.
- Adds configurable width, depth and port counts, registered reads with write-first bypass, and deterministic multi-write conflict resolution.
- Adds a cycle-accurate hardware clear sweep and sticky error flags.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width in bits; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- SP_IDX, 29, index of the stack-pointer entry.
- SP_RESET, 252, reset and clear value of entry SP_IDX.

Ports:
- elk  input  1  clock; all state updates on its rising edge.
- nrst  input  1  reset, synchronous, active-low.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i uses slice i.
- rd_data  output  NUM_RD*DATA_W  packed registered read data.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*ADDR_W  packed write addresses.
- wr_data  input  NUM_WR*DATA_W  packed write data.
- clr_req  input  1  single-cycle request to start the clear sweep.
- clr_busy  output  1  high while the sweep runs.
- wr_drop  output  1  one-cycle pulse: at least one enabled write was discarded because of the sweep.
- wr_conflict  output  1  one-cycle pulse: two or more enabled ports targeted the same nonzero address.
- wr_zero_err  output  1  sticky flag: some enabled write targeted address 0.

Behaviour:
- Reset (nrst=0 at a rising edge of elk):
  - All entries become 0, except entry SP_IDX, which becomes SP_RESET.
  - rd_data=0, clr_busy=0, wr_drop=0, wr_conflict=0, wr_zero_err=0.
  - The sweep FSM goes to IDLE with ptr=1.
  - Reset overrides every other input in that cycle.
- Entry 0 is hardwired to 0:
  - Writes to entry 0 are discarded and set wr_zero_err on the same edge.
  - wr_zero_err is cleared only by reset.
- Writes take effect on the rising edge in which wr_en[j]=1.
  - If several ports target the same address, the highest-indexed port wins.
  - wr_conflict is registered and high for exactly the following cycle.
- Reads have 1-cycle latency: rd_data slice i at edge t+1 = entry rd_addr[i] as sampled at edge t.
  - Write-first bypass: if a write (including a sweep write) to that address commits on edge t, rd_data returns the new value.
  - Bypass uses the same highest-port-wins priority as the write itself.
  - rd_addr=0 always returns 0.
- Sweep FSM has two states, IDLE and SWEEP:
  - IDLE to SWEEP on clr_req=1; ptr=1.
  - In SWEEP, each cycle writes the clear value to entry ptr (0, or SP_RESET when ptr==SP_IDX), then ptr increments.
  - After entry DEPTH-1 is written, the FSM returns to IDLE with ptr=1. The sweep lasts exactly DEPTH-1 cycles.
  - clr_busy=1 for exactly those DEPTH-1 cycles, starting the cycle after clr_req is sampled.
  - clr_req while in SWEEP is ignored; no restart.
- Writes while clr_busy=1 are all discarded and wr_drop pulses.
  - wr_zero_err and wr_conflict are still evaluated on those writes.
- Reads during SWEEP are allowed and return current contents, with bypass of the sweep write.
- nrst low mid-sweep aborts the sweep and performs a full reset.
- A write on the same edge as clr_req is sampled still commits, because clr_busy is still 0.
- Address arithmetic: ptr is ADDR_W bits and never wraps past DEPTH-1 (the terminal check precedes increment). No arithmetic is performed on data.

Decomposition:
- Package regfile_pkg holds:
  - the sweep state enumeration (IDLE, SWEEP);
  - the constant ZERO_IDX=0;
  - helper functions for the clear value and for packed-slice extraction.
- Sub-module regfile_clr_seq contains the sweep FSM, ptr counter, clr_busy and the sweep write strobe/address/data.
- Storage, the write-priority mux, bypass and the flags stay in regfile_mp.

Test Plan:
- Reset then read: nrst=0 for 2 cycles, release, read addr 29 and 5 -> rd_data=252 and 0 one cycle later; all flags 0.
- Write then read: port0 writes 0xDEADBEEF to addr 7; the next cycle reads addr 7 -> 0xDEADBEEF.
  - Same-cycle read of addr 7 -> bypass returns 0xDEADBEEF at t+1.
- Conflict: port0 writes 0x11 and port1 writes 0x22 to addr 3 on the same edge -> entry 3=0x22, wr_conflict high for 1 cycle, bypass read returns 0x22.
- Zero writes: write 0x55 to addr 0 -> read addr 0 returns 0, wr_zero_err=1 and stays 1 until nrst.
- Sweep: preload addr 1, 29 and 31 with 0xFF, pulse clr_req -> clr_busy high for 31 cycles.
  - A write to addr 10 mid-sweep is dropped and wr_drop pulses.
  - Afterwards addr 1=0, 29=252, 31=0, 10=0.
- Reset mid-sweep: start the sweep, assert nrst at cycle 5 -> clr_busy=0 next cycle, all entries at reset values, a new clr_req restarts at ptr=1.
